player_motion: RTL and testbench

Upstream motion and animation controller for the blue player sprite. It turns debounced directional and jump buttons into the sprite's top-left screen position, a walk-cycle frame index and a motion state. The display stage consumes these outputs to address the sprite ROMs and select among the six animation frames. All state advances only on a one-cycle frame tick, so motion speed is independent of the system clock.

---
 rtl/player_motion.sv | 182 ++++++++++++++++++
 tb/tb_player_motion.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Motion and walk-cycle animation controller for the blue player sprite.
// All architectural state advances only on the one-cycle frame tick.
module player_motion #(
  parameter int unsigned X_INIT    = 0,
  parameter int unsigned X_MAX     = 593,
  parameter int unsigned FLOOR_Y   = 360,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned JUMP_VEL  = 12,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned MAX_FALL  = 12,
  parameter int unsigned ANIM_DIV  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic [2:0] anim_frame,
  output logic       facing,
  output logic [1:0] state
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWalk = 2'd1;
  localparam logic [1:0] StJump = 2'd2;
  localparam logic [1:0] StFall = 2'd3;

  localparam int unsigned CntW = $clog2(ANIM_DIV) + 1;

  localparam logic signed [10:0] StepS      = 11'(WALK_STEP);
  localparam logic signed [10:0] XMaxS      = 11'(X_MAX);
  localparam logic signed [10:0] FloorS     = 11'(FLOOR_Y);
  localparam logic signed [10:0] GravS      = 11'(GRAVITY);
  localparam logic signed [10:0] MaxFallNeg = -11'(MAX_FALL);
  localparam logic signed [5:0]  JumpVy     = 6'(JUMP_VEL);

  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic signed [5:0] vy_q, vy_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        frame_q, frame_d;
  logic              facing_q, facing_d;
  logic              jump_prev_q, jump_prev_d;
  logic              jump_pend_q, jump_pend_d;
  logic [CntW-1:0]   walk_cnt_q, walk_cnt_d;

  logic              jump_rise, jump_req;
  logic              dir_right, dir_left, moving;
  logic signed [10:0] x_s, x_new;
  logic signed [10:0] y_s, vy_s, cand, vy_dec;
  logic [1:0]        ground_state;

  always_comb begin
    jump_rise   = btn_jump & ~jump_prev_q;
    jump_req    = jump_pend_q | jump_rise;
    jump_prev_d = btn_jump;
    // A pending request lives only until the next tick, consumed or not.
    jump_pend_d = tick ? 1'b0 : (jump_pend_q | jump_rise);

    dir_right    = btn_right & ~btn_left;
    dir_left     = btn_left & ~btn_right;
    moving       = dir_right | dir_left;
    ground_state = moving ? StWalk : StIdle;

    x_s = {1'b0, x_q};
    if (dir_right) begin
      x_new = x_s + StepS;
    end else if (dir_left) begin
      x_new = x_s - StepS;
    end else begin
      x_new = x_s;
    end
    if (x_new < 11'sd0) begin
      x_new = 11'sd0;
    end else if (x_new > XMaxS) begin
      x_new = XMaxS;
    end

    y_s    = {2'b00, y_q};
    vy_s   = {{5{vy_q[5]}}, vy_q};
    cand   = y_s - vy_s;
    vy_dec = vy_s - GravS;
    if (vy_dec < MaxFallNeg) begin
      vy_dec = MaxFallNeg;
    end
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    state_d    = state_q;
    facing_d   = facing_q;
    frame_d    = frame_q;
    walk_cnt_d = walk_cnt_q;

    if (tick) begin
      x_d = x_new[9:0];
      if (dir_right) begin
        facing_d = 1'b0;
      end else if (dir_left) begin
        facing_d = 1'b1;
      end

      if (!state_q[1]) begin
        if (jump_req) begin
          vy_d    = JumpVy;
          state_d = StJump;
        end else begin
          state_d = ground_state;
        end
      end else begin
        if (cand < 11'sd0) begin
          y_d     = 9'd0;
          vy_d    = 6'sd0;
          state_d = StFall;
        end else if ((vy_s <= 11'sd0) && (cand >= FloorS)) begin
          y_d     = FloorS[8:0];
          vy_d    = 6'sd0;
          state_d = ground_state;
        end else begin
          y_d  = cand[8:0];
          vy_d = vy_dec[5:0];
          if ((state_q == StJump) && (vy_dec <= 11'sd0)) begin
            state_d = StFall;
          end
        end
      end

      // Only a tick that stays in WALK advances the cycle; entry restarts at frame 0.
      if ((state_d == StWalk) && (state_q == StWalk)) begin
        if (walk_cnt_q == CntW'(ANIM_DIV - 1)) begin
          walk_cnt_d = '0;
          frame_d    = (frame_q == 3'd5) ? 3'd0 : frame_q + 3'd1;
        end else begin
          walk_cnt_d = walk_cnt_q + CntW'(1);
        end
      end else begin
        walk_cnt_d = '0;
        unique case (state_d)
          StJump:  frame_d = 3'd3;
          StFall:  frame_d = 3'd4;
          default: frame_d = 3'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q         <= 10'(X_INIT);
      y_q         <= 9'(FLOOR_Y);
      vy_q        <= 6'sd0;
      state_q     <= StIdle;
      frame_q     <= 3'd0;
      facing_q    <= 1'b0;
      jump_prev_q <= 1'b0;
      jump_pend_q <= 1'b0;
      walk_cnt_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      state_q     <= state_d;
      frame_q     <= frame_d;
      facing_q    <= facing_d;
      jump_prev_q <= jump_prev_d;
      jump_pend_q <= jump_pend_d;
      walk_cnt_q  <= walk_cnt_d;
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign anim_frame = frame_q;
  assign facing     = facing_q;
  assign state      = state_q;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: stimulus pushes model predictions per tick,
// a monitor pops and compares after every clock edge.
module tb_player_motion;
  localparam int XMax  = 593;
  localparam int Floor = 360;
  localparam int Step  = 2;
  localparam int JVel  = 12;
  localparam int Grav  = 1;
  localparam int MFall = 12;
  localparam int Anim  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic [2:0] anim_frame;
  logic       facing;
  logic [1:0] state;

  player_motion dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .anim_frame (anim_frame),
    .facing     (facing),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] fr;
    logic       fc;
    logic [1:0] st;
  } obs_t;

  obs_t exp_q[$];
  obs_t last_exp;
  int   total = 0;
  int   bad = 0;

  // Reference model: positions, velocity, state and ticks spent walking.
  int m_x, m_y, m_vy, m_st, m_wt, m_fc, m_pend, m_prevb;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x  = 10'(m_x);
    o.y  = 9'(m_y);
    o.st = 2'(m_st);
    o.fc = m_fc[0];
    if (m_st == 1)      o.fr = 3'((m_wt / Anim) % 6);
    else if (m_st == 2) o.fr = 3'd3;
    else if (m_st == 3) o.fr = 3'd4;
    else                o.fr = 3'd0;
    return o;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = Floor; m_vy = 0; m_st = 0; m_wt = 0; m_fc = 0; m_pend = 0; m_prevb = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j, input bit t);
    int rise, jmp, dir, prev_st, cand;
    rise    = (j && !m_prevb) ? 1 : 0;
    m_prevb = j;
    if (!t) begin
      if (rise != 0) m_pend = 1;
      return;
    end
    jmp    = (m_pend != 0 || rise != 0) ? 1 : 0;
    m_pend = 0;
    dir    = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    if (dir != 0) m_fc = (dir < 0) ? 1 : 0;
    m_x = m_x + dir * Step;
    if (m_x < 0) m_x = 0;
    if (m_x > XMax) m_x = XMax;
    prev_st = m_st;
    if (m_st < 2) begin
      if (jmp != 0) begin
        m_vy = JVel; m_st = 2;
      end else begin
        m_st = (dir != 0) ? 1 : 0;
      end
    end else begin
      cand = m_y - m_vy;
      if (cand < 0) begin
        m_y = 0; m_vy = 0; m_st = 3;
      end else if (m_vy <= 0 && cand >= Floor) begin
        m_y = Floor; m_vy = 0; m_st = (dir != 0) ? 1 : 0;
      end else begin
        m_y  = cand;
        m_vy = m_vy - Grav;
        if (m_vy < -MFall) m_vy = -MFall;
        if (m_st == 2 && m_vy <= 0) m_st = 3;
      end
    end
    if (m_st == 1) m_wt = (prev_st == 1) ? m_wt + 1 : 0;
    else m_wt = 0;
  endtask

  task automatic cyc(input bit l, input bit r, input bit j, input bit t);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; tick = t;
    model_step(l, r, j, t);
    if (t) exp_q.push_back(model_obs());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    rstn = 1'b0;
    model_reset();
    last_exp = model_obs();
    #1;
    if (check_now) begin
      chk("rst_x", int'(x_pos), 0);
      chk("rst_y", int'(y_pos), Floor);
      chk("rst_state", int'(state), 0);
      chk("rst_frame", int'(anim_frame), 0);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: pop on every sampled tick, otherwise outputs must hold.
  always begin
    bit saw;
    @(posedge clk);
    saw = tick;
    #1;
    if (saw) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow got=empty want=entry at %0t", $time);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    total++;
    if ({x_pos, y_pos, anim_frame, facing, state} !== last_exp) begin
      bad++;
      $display("FAIL %s got x=%0d y=%0d fr=%0d fc=%0d st=%0d want x=%0d y=%0d fr=%0d fc=%0d st=%0d at %0t",
               saw ? "tick_out" : "hold_out", x_pos, y_pos, anim_frame, facing, state,
               last_exp.x, last_exp.y, last_exp.fr, last_exp.fc, last_exp.st, $time);
    end
  end

  initial begin
    int n;
    bit l, r, j;
    model_reset();
    last_exp = model_obs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Walk right 10 ticks, then release.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("walk_x", int'(x_pos), 20);
    chk("walk_state", int'(state), 1);
    chk("walk_frame", int'(anim_frame), 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("release_state", int'(state), 0);

    // Saturation at both edges with back-to-back ticks.
    do_reset(1'b0);
    for (int i = 0; i < 297; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("sat_right", int'(x_pos), XMax);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("sat_hold_state", int'(state), 1);
    for (int i = 0; i < 296; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("near_left", int'(x_pos), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("sat_left", int'(x_pos), 0);
    chk("sat_facing", int'(facing), 1);

    // Jump arc with an ignored mid-air edge.
    do_reset(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("launch_state", int'(state), 2);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("apex_y", int'(y_pos), 282);
    chk("apex_state", int'(state), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n = 13;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
      settle();
      if (state == 2'd0) break;
    end
    chk("land_tick", n, 26);
    chk("land_y", int'(y_pos), Floor);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("no_rejump", int'(state), 0);

    // Edge three cycles ahead of the tick: exactly one jump.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("early_edge_jump", int'(state), 2);

    // Reset mid-flight snaps to the floor at once.
    for (int i = 0; i < 10 && m_y > 320; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1'b1);

    // Edge coincident with tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("coincident_jump", int'(state), 2);

    // Both directions held.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("both_x", int'(x_pos), 4);
    chk("both_facing", int'(facing), 1);
    chk("both_state", int'(state), 0);

    // Randomized traffic with occasional mid-run resets.
    j = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      l = 1'($urandom % 2);
      r = 1'($urandom % 2);
      if ($urandom_range(0, 3) == 0) j = ~j;
      if ($urandom_range(0, 699) == 0) do_reset(1'b1);
      else cyc(l, r, j, ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
